// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit control for a single-issue pipeline.
// Accepts one load or store from the execute stage, checks size/alignment,
// drives a word-aligned request on the data bus with lane enables and
// replicated store data, waits for an acknowledge (bounded by TIMEOUT) and
// returns extended load data as a one-cycle writeback strobe.
module lsu_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        ex_valid,
   input  logic        mem_rd,
   input  logic        mem_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd_idx,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        access_err,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // Last counter value before the access is abandoned.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

   state_t      state_r;
   state_t      state_next_s;
   logic [7:0]  wait_cnt_r;
   logic [7:0]  wait_cnt_next_s;

   logic        op_s;
   logic        both_s;
   logic        legal_s;
   logic        illegal_s;
   logic        start_s;
   logic        ack_s;
   logic        timeout_s;

   logic        kind_store_r;
   logic [2:0]  funct3_r;
   logic [1:0]  off_r;
   logic [4:0]  rd_r;

   // Size/sign code and alignment legality for a load or a store.
   function automatic logic op_legal(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] off);
      logic ok;
      case (f3)
         3'b000:  ok = 1'b1;
         3'b001:  ok = (off[0] == 1'b0);
         3'b010:  ok = (off == 2'b00);
         3'b100:  ok = ~is_store;
         3'b101:  ok = ~is_store & (off[0] == 1'b0);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte-lane enables; unsigned variants share the signed lane pattern.
   function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << {off[1], 1'b0};
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Store data replicated across every lane the access could select.
   function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] res;
      case (f3[1:0])
         2'b00:   res = {4{wd[7:0]}};
         2'b01:   res = {2{wd[15:0]}};
         2'b10:   res = wd;
         default: res = wd;
      endcase
      return res;
   endfunction

   // Align the addressed bytes to bit 0 and sign- or zero-extend them.
   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
      logic [31:0] sh;
      logic [31:0] res;
      sh = rdata >> {off, 3'b000};
      case (f3)
         3'b000:  res = {{24{sh[7]}}, sh[7:0]};
         3'b001:  res = {{16{sh[15]}}, sh[15:0]};
         3'b010:  res = sh;
         3'b100:  res = {24'h000000, sh[7:0]};
         3'b101:  res = {16'h0000, sh[15:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

   // Decode of the execute-stage request; only meaningful while idle.
   always_comb begin
      op_s      = ex_valid & (mem_rd ^ mem_we);
      both_s    = ex_valid & mem_rd & mem_we;
      legal_s   = op_s & op_legal(mem_we, funct3, addr[1:0]);
      illegal_s = (state_r == ST_IDLE) &
                  (both_s | (op_s & ~op_legal(mem_we, funct3, addr[1:0])));
   end

   // Freeze earlier stages while busy or while a legal op is being taken.
   assign stall = (state_r != ST_IDLE) | legal_s;

   // State and wait-counter registers.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_r    <= ST_IDLE;
         wait_cnt_r <= 8'd0;
      end else begin
         state_r    <= state_next_s;
         wait_cnt_r <= wait_cnt_next_s;
      end
   end

   // Next-state logic; an ack in the final wait cycle beats the timeout.
   always_comb begin
      state_next_s    = state_r;
      wait_cnt_next_s = wait_cnt_r;
      start_s         = 1'b0;
      ack_s           = 1'b0;
      timeout_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (legal_s) begin
               state_next_s    = ST_REQ;
               wait_cnt_next_s = 8'd0;
               start_s         = 1'b1;
            end else begin
               state_next_s    = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (dmem_ack) begin
               ack_s        = 1'b1;
               state_next_s = kind_store_r ? ST_IDLE : ST_RESP;
            end else if (wait_cnt_r == CNT_LAST) begin
               timeout_s    = 1'b1;
               state_next_s = ST_IDLE;
            end else begin
               wait_cnt_next_s = wait_cnt_r + 8'd1;
            end
         end
         ST_RESP: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s    = ST_IDLE;
            wait_cnt_next_s = 8'd0;
         end
      endcase
   end

   // Bus-side outputs and captured operation fields, held for the whole request.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= 32'h0000_0000;
         dmem_be      <= 4'b0000;
         dmem_wdata   <= 32'h0000_0000;
         kind_store_r <= 1'b0;
         funct3_r     <= 3'b000;
         off_r        <= 2'b00;
         rd_r         <= 5'd0;
      end else if (start_s) begin
         dmem_req     <= 1'b1;
         dmem_we      <= mem_we;
         dmem_addr    <= {addr[31:2], 2'b00};
         dmem_be      <= lane_be(funct3, addr[1:0]);
         dmem_wdata   <= lane_wdata(funct3, wdata);
         kind_store_r <= mem_we;
         funct3_r     <= funct3;
         off_r        <= addr[1:0];
         rd_r         <= rd_idx;
      end else if (ack_s | timeout_s) begin
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_be      <= 4'b0000;
      end
   end

   // Writeback strobe/data and the one-cycle error pulses.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         wb_valid   <= 1'b0;
         wb_rd      <= 5'd0;
         wb_data    <= 32'h0000_0000;
         access_err <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         access_err <= illegal_s;
         bus_err    <= timeout_s;
         if (ack_s & ~kind_store_r) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_r;
            wb_data  <= load_extend(funct3_r, off_r, dmem_rdata);
         end else begin
            wb_valid <= 1'b0;
         end
      end
   end

endmodule
